radar_sweep_gen: RTL



---
 rtl/radar_pkg.sv | 30 +++
 rtl/radar_target_bank.sv | 63 ++++++
 rtl/radar_sweep_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/radar_pkg.sv
// Shared types and constants for the synthetic radar sweep source.
// Noise option: RADAR_SWEEP_NOISE_EN enables the LFSR dither helpers below.
package radar_pkg;

    localparam int VID_W    = 12;
    localparam int SAMPLE_W = 12;
    localparam int NUM_TGT  = 4;
    localparam int ACC_W    = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIG,
        ST_SWEEP,
        ST_DEAD
    } state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] rng;
        logic [VID_W-1:0]    amp;
    } tgt_t;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/radar_target_bank.sv
// Live/shadow point-target registers and the summed target amplitude
// for one sample index. Shadow set is frozen for the whole PRI.
module radar_target_bank
    import radar_pkg::*;
#(
    parameter int TGT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [1:0]          i_idx,
    input  logic [SAMPLE_W-1:0] i_range,
    input  logic [VID_W-1:0]    i_amp,
    input  logic                i_load,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [ACC_W-1:0]    o_sum
);

    tgt_t              r_live   [NUM_TGT];
    tgt_t              r_shadow [NUM_TGT];
    logic              w_hit    [NUM_TGT];
    logic [ACC_W-1:0]  w_sum;

    // Shadow takes the old live set on load; a same-edge write goes to live only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TGT; k++) begin
                r_live[k]   <= '0;
                r_shadow[k] <= '0;
            end
        end else begin
            if (i_load) begin
                r_shadow <= r_live;
            end
            if (i_we) begin
                r_live[i_idx] <= '{rng: i_range, amp: i_amp};
            end
        end
    end

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_hit
        logic [SAMPLE_W:0] w_lo;
        logic [SAMPLE_W:0] w_hi;
        logic [SAMPLE_W:0] w_s;
        assign w_lo     = {1'b0, r_shadow[g].rng};
        assign w_hi     = w_lo + (SAMPLE_W+1)'(TGT_WIDTH - 1);
        assign w_s      = {1'b0, i_sample};
        assign w_hit[g] = (w_s >= w_lo) && (w_s <= w_hi);
    end

    // Sum amplitudes of all targets whose window covers the sample
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (w_hit[k]) begin
                w_sum = w_sum + {2'b00, r_shadow[k].amp};
            end
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/radar_sweep_gen.sv
// Synthetic radar sweep: trigger pulse, then clutter + point-target video.
// Build option RADAR_SWEEP_NOISE_EN adds 4-bit LFSR noise to the video.
module radar_sweep_gen
    import radar_pkg::*;
#(
    parameter int PRI_CYCLES  = 8192,
    parameter int TRIG_WIDTH  = 4,
    parameter int SWEEP_LEN   = 4095,
    parameter int TGT_WIDTH   = 4,
    parameter int CLUTTER_AMP = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_idx,
    input  logic [11:0] cfg_range,
    input  logic [11:0] cfg_amp,
    output logic        trig,
    output logic [11:0] vid_out,
    output logic        vid_valid,
    output logic [11:0] sample_idx,
    output logic        busy
);

    localparam int PRI_W = $clog2(PRI_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SAMPLE_W-1:0] r_cnt;
    logic [SAMPLE_W-1:0] w_cnt_nxt;
    logic [PRI_W-1:0]    r_pri;
    logic                w_load;
    logic                w_sweep_nxt;
    logic [SAMPLE_W-1:0] w_idx_nxt;
    logic [ACC_W-1:0]    w_tgt;
    logic [VID_W-1:0]    w_clut;
    logic [3:0]          w_noise;
    logic [ACC_W:0]      w_acc;
    logic [VID_W-1:0]    w_vid;
    logic                r_trig;
    logic                r_valid;
    logic [SAMPLE_W-1:0] r_idx;
    logic [VID_W-1:0]    r_vid;

    // State register and per-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state; w_load marks every TRIG-entry edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_TRIG;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_TRIG: begin
                if (r_cnt == SAMPLE_W'(TRIG_WIDTH - 1)) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (r_cnt == SAMPLE_W'(SWEEP_LEN)) begin
                    w_state_nxt = ST_DEAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DEAD: begin
                if (r_pri == PRI_W'(PRI_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (enable) begin
                        w_state_nxt = ST_TRIG;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // PRI counter: zero on TRIG entry and in IDLE, else free-running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pri <= '0;
        end else if (w_load || w_state_nxt == ST_IDLE) begin
            r_pri <= '0;
        end else begin
            r_pri <= r_pri + 1'b1;
        end
    end

    assign w_sweep_nxt = (w_state_nxt == ST_SWEEP);
    assign w_idx_nxt   = w_sweep_nxt ? w_cnt_nxt : '0;

    radar_target_bank #(
        .TGT_WIDTH (TGT_WIDTH)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (cfg_we),
        .i_idx    (cfg_idx),
        .i_range  (cfg_range),
        .i_amp    (cfg_amp),
        .i_load   (w_load),
        .i_sample (w_idx_nxt),
        .o_sum    (w_tgt)
    );

`ifdef RADAR_SWEEP_NOISE_EN
    logic [15:0] r_lfsr;

    // Noise source advances every clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_noise = r_lfsr[3:0];
`else
    assign w_noise = 4'd0;
`endif

    // Clutter halves every 256 samples; shifts past 11 fall to zero
    assign w_clut = VID_W'(CLUTTER_AMP) >> w_idx_nxt[11:8];
    assign w_acc  = {1'b0, w_tgt}
                  + {3'b000, w_clut}
                  + {11'd0, w_noise};
    assign w_vid  = (|w_acc[ACC_W:VID_W]) ? {VID_W{1'b1}} : w_acc[VID_W-1:0];

    // Registered outputs, all aligned to the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_vid   <= '0;
        end else begin
            r_trig  <= (w_state_nxt == ST_TRIG);
            r_valid <= w_sweep_nxt;
            r_idx   <= w_idx_nxt;
            r_vid   <= w_sweep_nxt ? w_vid : '0;
        end
    end

    assign trig       = r_trig;
    assign vid_valid  = r_valid;
    assign sample_idx = r_idx;
    assign vid_out    = r_vid;
    assign busy       = (r_state != ST_IDLE);

endmodule
